serial_baud_gen: RTL

SERIAL_BAUD_GEN -- requirements
Module: serial_baud_gen

---
 rtl/serial_pkg.sv | 20 ++
 rtl/serial_baud_t1.sv | 29 ++
 rtl/serial_baud_gen.sv | 116 +++++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the serial port blocks: mode encodings and default rates.
// serial_top uses the same encodings to decode SCON.
package serial_pkg;

  typedef enum logic [1:0] {
    SERIAL_MODE0 = 2'b00,
    SERIAL_MODE1 = 2'b01,
    SERIAL_MODE2 = 2'b10,
    SERIAL_MODE3 = 2'b11
  } serial_mode_e;

  localparam int SERIAL_PRESCALE_DEF   = 12;
  localparam int SERIAL_OVERSAMPLE_DEF = 16;

  // Modes 1 and 3 take their bit rate from timer-1 overflows.
  function automatic logic mode_uses_t1(input serial_mode_e m);
    return (m == SERIAL_MODE1) || (m == SERIAL_MODE3);
  endfunction

endpackage

// File: rtl/serial_baud_t1.sv
// Timer 1 in 8-bit auto-reload mode: TL1 counts machine ticks and reloads
// from TH1 on overflow; it tracks TH1 continuously while stopped.
module serial_baud_t1 (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_mtick,
  input  logic       i_tr1,
  input  logic [7:0] i_th1,
  output logic       o_ovf
);

  logic [7:0] r_tl1;
  logic       w_ovf;

  assign w_ovf = i_tr1 & i_mtick & (r_tl1 == 8'hFF);
  assign o_ovf = w_ovf;

  // A TH1 write while running is only picked up by the overflow reload.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tl1 <= 8'h00;
    end else if (!i_tr1 || w_ovf) begin
      r_tl1 <= i_th1;
    end else if (i_mtick) begin
      r_tl1 <= r_tl1 + 8'd1;
    end
  end

endmodule

// File: rtl/serial_baud_gen.sv
// Baud-rate generator for the serial port: derives the receive sample strobe,
// transmit bit strobe and timer-1 overflow strobe from the SCON/PCON mode.
module serial_baud_gen
  import serial_pkg::*;
#(
  parameter int PRESCALE   = SERIAL_PRESCALE_DEF,
  parameter int OVERSAMPLE = SERIAL_OVERSAMPLE_DEF
) (
  input  logic       baud_clock_i,
  input  logic       baud_reset_i,
  input  logic       baud_scon7_sm0_i,
  input  logic       baud_scon6_sm1_i,
  input  logic       baud_pcon7_smod_i,
  input  logic       baud_tr1_i,
  input  logic [7:0] baud_th1_i,
  output logic       baud_br_o,
  output logic       baud_br_trans_o,
  output logic       baud_t1_ovf_o
);

  localparam int            PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [3:0]    OS_LAST  = 4'(OVERSAMPLE - 1);

  logic [PW-1:0] r_presc;
  serial_mode_e  r_mode;
  logic          r_smod;
  logic          r_half;
  logic [1:0]    r_m2cnt;
  logic [3:0]    r_os;
  logic          r_br;
  logic          r_br_trans;
  logic          r_t1_ovf;

  serial_mode_e  w_mode;
  logic          w_mtick;
  logic          w_ovf;
  logic          w_cfg_chg;
  logic          w_sample;
  logic          w_trans;

  assign w_mode    = serial_mode_e'({baud_scon7_sm0_i, baud_scon6_sm1_i});
  assign w_mtick   = (r_presc == PRE_LAST);
  assign w_cfg_chg = (w_mode != r_mode) || (baud_pcon7_smod_i != r_smod);

  serial_baud_t1 u_t1 (
    .i_clk   (baud_clock_i),
    .i_rst   (baud_reset_i),
    .i_mtick (w_mtick),
    .i_tr1   (baud_tr1_i),
    .i_th1   (baud_th1_i),
    .o_ovf   (w_ovf)
  );

  always_comb begin
    w_sample = 1'b0;
    w_trans  = 1'b0;
    case (w_mode)
      SERIAL_MODE0: begin
        w_sample = w_mtick;
        w_trans  = w_mtick;
      end
      SERIAL_MODE2: w_sample = baud_pcon7_smod_i ? r_m2cnt[0] : (r_m2cnt == 2'd3);
      default:      w_sample = w_ovf & (baud_pcon7_smod_i | r_half);
    endcase
    if (w_mode != SERIAL_MODE0) begin
      w_trans = w_sample & (r_os == OS_LAST);
    end
    // A tick landing on a configuration change belongs to neither rate.
    if (w_cfg_chg) begin
      w_sample = 1'b0;
      w_trans  = 1'b0;
    end
  end

  always_ff @(posedge baud_clock_i or posedge baud_reset_i) begin
    if (baud_reset_i) begin
      r_presc    <= '0;
      r_mode     <= SERIAL_MODE0;
      r_smod     <= 1'b0;
      r_half     <= 1'b0;
      r_m2cnt    <= 2'd0;
      r_os       <= 4'd0;
      r_br       <= 1'b0;
      r_br_trans <= 1'b0;
      r_t1_ovf   <= 1'b0;
    end else begin
      r_presc    <= w_mtick ? '0 : r_presc + PW'(1);
      r_mode     <= w_mode;
      r_smod     <= baud_pcon7_smod_i;
      r_br       <= w_sample;
      r_br_trans <= w_trans;
      r_t1_ovf   <= w_ovf;
      if (w_cfg_chg) begin
        r_half  <= 1'b0;
        r_m2cnt <= 2'd0;
        r_os    <= 4'd0;
      end else begin
        r_m2cnt <= (w_mode == SERIAL_MODE2) ? r_m2cnt + 2'd1 : 2'd0;
        if (mode_uses_t1(w_mode) && w_ovf) begin
          r_half <= ~r_half;
        end
        if (w_mode == SERIAL_MODE0) begin
          r_os <= 4'd0;
        end else if (w_sample) begin
          r_os <= (r_os == OS_LAST) ? 4'd0 : r_os + 4'd1;
        end
      end
    end
  end

  assign baud_br_o       = r_br;
  assign baud_br_trans_o = r_br_trans;
  assign baud_t1_ovf_o   = r_t1_ovf;

endmodule
